fp_to_int: RTL and testbench

- Sequential converter from the team's 13-bit floating-point format to an 8-bit two's-complement integer.
- Input format: sign, 4-bit unsigned exp, 8-bit frac; value = (frac/256) * 2^exp, with the frac MSB set when normalized.
- This is the consumer/decoder side of the fp adder output. It lets the adder result be read back as a plain integer for display or further integer logic.
- Uses one right shift per clock, with a start/ready/done_tick handshake.

---
 rtl/fp_to_int_pkg.sv | 25 ++
 rtl/fp_to_int_int_sat.sv | 44 ++++
 rtl/fp_to_int.sv | 105 ++++++++++
 tb/tb_fp_to_int.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fp_to_int_pkg.sv
// Shared constants for the 13-bit floating-point format and its integer view.
// The fp adder, its test circuit and this converter all import this package.
//   EXP_W / FRAC_W : fp exponent and fraction widths
//   INT_W          : two's-complement integer width
//   INT_MAX/INT_MIN: saturation values
//   St*            : converter FSM state encodings
package fp_to_int_pkg;

  localparam int unsigned EXP_W  = 4;
  localparam int unsigned FRAC_W = 8;
  localparam int unsigned INT_W  = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [INT_W-1:0] INT_MAX = 8'h7F;
  localparam logic [INT_W-1:0] INT_MIN = 8'h80;

  // Exponent at which frac maps onto the integer without shifting.
  localparam logic [EXP_W-1:0] EXP_INT  = 4'd8;
  localparam logic [CNT_W-1:0] CNT_FULL = 4'd8;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StOp   = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/fp_to_int_int_sat.sv
// int_sat: combinational rounding/saturation stage of fp_to_int.
// Turns the final (already shifted) magnitude into a signed integer.
//   sign     in  : fp sign
//   exp      in  : fp exponent as latched at start
//   mag      in  : final magnitude after the right shifts
//   q_next   out : signed integer, truncated toward zero, saturated
//   ovf_next out : set when q_next was saturated
module fp_to_int_int_sat
  import fp_to_int_pkg::*;
(
  input  logic             sign,
  input  logic [EXP_W-1:0] exp,
  input  logic [FRAC_W-1:0] mag,
  output logic [INT_W-1:0] q_next,
  output logic             ovf_next
);

  always_comb begin
    q_next   = '0;
    ovf_next = 1'b0;
    if (mag == '0) begin
      // Zero (including negative zero and any exp) reads as plain 0.
      q_next   = '0;
      ovf_next = 1'b0;
    end else if (exp > EXP_INT) begin
      q_next   = sign ? INT_MIN : INT_MAX;
      ovf_next = 1'b1;
    end else if (exp == EXP_INT) begin
      if (!mag[FRAC_W-1]) begin
        q_next = sign ? (~mag + 8'd1) : mag;
      end else if (mag == INT_MIN && sign) begin
        // -128 is representable exactly.
        q_next = INT_MIN;
      end else begin
        q_next   = sign ? INT_MIN : INT_MAX;
        ovf_next = 1'b1;
      end
    end else begin
      // At least one shift happened, so mag <= 127 here.
      q_next = sign ? (~mag + 8'd1) : mag;
    end
  end

endmodule

// File: rtl/fp_to_int.sv
// fp_to_int: sequential converter from the 13-bit fp format (sign, 4-bit exp,
// 8-bit frac, value = frac/256 * 2^exp) to an 8-bit two's-complement integer.
// One right shift per clock; start/ready/done_tick handshake.
//   clk       in  : system clock, rising edge
//   reset     in  : asynchronous active-high reset
//   start     in  : request a conversion, sampled only while ready
//   sign/exp/frac in : fp operand
//   ready     out : high while idle
//   done_tick out : one-cycle pulse, q/ovf already hold the new result
//   q         out : signed result, truncated toward zero, saturated
//   ovf       out : result was saturated
module fp_to_int
  import fp_to_int_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sign,
  input  logic [EXP_W-1:0]  exp,
  input  logic [FRAC_W-1:0] frac,
  output logic              ready,
  output logic              done_tick,
  output logic [INT_W-1:0]  q,
  output logic              ovf
);

  logic [1:0]        state_q, state_d;
  logic              sign_q, sign_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [FRAC_W-1:0] mag_q, mag_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [INT_W-1:0]  q_q, q_next;
  logic              ovf_q, ovf_next;
  logic              load_res;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mag_d   = mag_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sign_d = sign;
          exp_d  = exp;
          mag_d  = frac;
          if (frac == '0 || exp >= EXP_INT) begin
            state_d = StDone;
          end else begin
            count_d = CNT_FULL - exp;
            state_d = StOp;
          end
        end
      end
      StOp: begin
        mag_d   = mag_q >> 1;
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Result is computed from the next-state operand so it is already valid
  // in the done_tick cycle, whichever path enters done.
  assign load_res = (state_d == StDone) && (state_q != StDone);

  fp_to_int_int_sat u_int_sat (
    .sign     (sign_d),
    .exp      (exp_d),
    .mag      (mag_d),
    .q_next   (q_next),
    .ovf_next (ovf_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mag_q   <= '0;
      count_q <= '0;
      q_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mag_q   <= mag_d;
      count_q <= count_d;
      if (load_res) begin
        q_q   <= q_next;
        ovf_q <= ovf_next;
      end
    end
  end

  assign ready     = (state_q == StIdle);
  assign done_tick = (state_q == StDone);
  assign q         = q_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fp_to_int.sv
// Directed self-checking bench for fp_to_int. Expected results come from an
// arithmetic model of the fp value and are queued at start, popped at done_tick.
module tb_fp_to_int;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       sign;
  logic [3:0] exp;
  logic [7:0] frac;
  logic       ready;
  logic       done_tick;
  logic [7:0] q;
  logic       ovf;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] q;
    logic       ovf;
    int         lat;
  } exp_t;

  exp_t sb[$];

  fp_to_int dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sign      (sign),
    .exp       (exp),
    .frac      (frac),
    .ready     (ready),
    .done_tick (done_tick),
    .q         (q),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic exp_t model(input logic s, input logic [3:0] e, input logic [7:0] f);
    exp_t r;
    int   v;
    r.lat = (f == 8'd0 || e >= 4'd8) ? 1 : 9 - int'(e);
    r.q   = 8'h00;
    r.ovf = 1'b0;
    if (f == 8'd0) begin
      r.q = 8'h00;
    end else if (e > 4'd8) begin
      r.q   = s ? 8'h80 : 8'h7F;
      r.ovf = 1'b1;
    end else begin
      v = int'(f) >> (8 - int'(e));
      if (s) v = -v;
      if (v > 127 || v < -128) begin
        r.q   = s ? 8'h80 : 8'h7F;
        r.ovf = 1'b1;
      end else begin
        r.q = v[7:0];
      end
    end
    return r;
  endfunction

  // Called at a negedge while idle; returns at the negedge one cycle after
  // done_tick, so the next call starts back-to-back.
  task automatic convert(input logic s, input logic [3:0] e, input logic [7:0] f,
                         input bit disturb);
    exp_t want;
    int   lat;
    bit   busy_ok;
    bit   done_seen;
    sb.push_back(model(s, e, f));
    check("idle_ready", 32'(ready), 32'd1);
    sign  = s;
    exp   = e;
    frac  = f;
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    lat       = 0;
    busy_ok   = 1'b1;
    done_seen = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (ready !== 1'b0) busy_ok = 1'b0;
      if (done_tick === 1'b1) begin
        lat       = c;
        done_seen = 1'b1;
        break;
      end
      if (disturb) begin
        start = 1'b1;
        sign  = 1'($urandom);
        exp   = 4'($urandom);
        frac  = 8'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    want  = sb.pop_front();
    check("done_seen", 32'(done_seen), 32'd1);
    check("latency", 32'(lat), 32'(want.lat));
    check("busy_ready_low", 32'(busy_ok), 32'd1);
    check("q", 32'(q), 32'(want.q));
    check("ovf", 32'(ovf), 32'(want.ovf));
    @(negedge clk);
    check("single_pulse", 32'(done_tick), 32'd0);
    check("q_hold", 32'(q), 32'(want.q));
  endtask

  initial begin
    bit late_done;
    reset = 1'b1;
    start = 1'b0;
    sign  = 1'b0;
    exp   = 4'd0;
    frac  = 8'd0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done_tick), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    convert(1'b0, 4'd4,  8'hA0, 1'b0);  // q=0A, 5 cycles
    convert(1'b1, 4'd3,  8'hE0, 1'b0);  // q=F9, 6 cycles
    convert(1'b1, 4'd0,  8'hFF, 1'b0);  // q=00, 9 cycles
    convert(1'b1, 4'd8,  8'h80, 1'b0);  // q=80, ovf=0
    convert(1'b0, 4'd8,  8'h80, 1'b0);  // q=7F, ovf=1
    convert(1'b1, 4'd12, 8'h90, 1'b0);  // q=80, ovf=1
    convert(1'b1, 4'd15, 8'h00, 1'b0);  // q=00, 1 cycle
    convert(1'b0, 4'd5,  8'h7F, 1'b0);  // q=0F
    convert(1'b0, 4'd0,  8'hC0, 1'b1);  // busy starts/input changes ignored
    convert(1'b0, 4'd7,  8'hFE, 1'b0);  // back-to-back, q=7F ovf=0
    convert(1'b1, 4'd6,  8'hB4, 1'b0);  // q=D3

    // Reset three cycles into an exp=2 run.
    sign  = 1'b0;
    exp   = 4'd2;
    frac  = 8'hC0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_q", 32'(q), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    late_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done_tick !== 1'b0) late_done = 1'b1;
    end
    check("abort_no_done", 32'(late_done), 32'd0);

    convert(1'b1, 4'd1,  8'h80, 1'b0);  // q=FF, 8 cycles

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
